// File: rtl/serial_cmd_pkg.sv
// Shared types and widths for the bit-serial command decoder.
package serial_cmd_pkg;

    localparam int OPC_W      = 2;
    localparam int DEF_ADR_W  = 2;
    localparam int DEF_DATA_W = 8;
    localparam int PAYLOAD_W  = OPC_W + DEF_ADR_W + DEF_DATA_W;

    typedef enum logic [OPC_W-1:0] {
        OPC_NOP    = 2'b00,
        OPC_STORE  = 2'b01,
        OPC_FETCH  = 2'b10,
        OPC_DIRECT = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SHIFT,
        ST_STOP,
        ST_ISSUE,
        ST_WAIT_IDLE
    } state_t;

    function automatic int payload_w(input int adr_w, input int data_w);
        return OPC_W + adr_w + data_w;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period down-counter: load sets the count, expire_o pulses for one cycle at zero.
module serial_bit_timer #(
    parameter  int CLKS_PER_BIT = 4,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load_i) begin
            cnt_d = load_val_i;
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign expire_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/serial_cmd_decoder.sv
// Bit-serial command receiver: deserializes opcode/address/data and issues strobes.
//   state     | meaning
//   IDLE      | line idle, waiting for a falling edge
//   START     | timing to mid start bit, reject glitches
//   SHIFT     | sampling payload bits mid-bit, LSB first
//   STOP      | sampling stop bit
//   ISSUE     | strobes and new adr/data visible for one cycle
//   WAIT_IDLE | bad stop seen, waiting for line to return high
module serial_cmd_decoder
    import serial_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADR_W        = DEF_ADR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ser_i,
    output logic [DATA_W-1:0] data_o,
    output logic [ADR_W-1:0]  adr_o,
    output logic              read_sig_o,
    output logic              write_sig_o,
    output logic              busy_o,
    output logic              frame_err_o
);

    localparam int PLD_W = payload_w(ADR_W, DATA_W);
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W = $clog2(PLD_W);

    localparam logic [TMR_W-1:0] HALF_BIT = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_BIT = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PLD_W - 1);

    state_t            state_q, state_d;
    logic              ser_meta_q, ser_meta_d;
    logic              ser_s_q, ser_s_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [PLD_W-1:0]  payload_q, payload_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_expire;

    opcode_t           pld_opc;
    logic [ADR_W-1:0]  pld_adr;
    logic [DATA_W-1:0] pld_data;

    assign pld_opc  = opcode_t'(payload_q[OPC_W-1:0]);
    assign pld_adr  = payload_q[OPC_W +: ADR_W];
    assign pld_data = payload_q[OPC_W+ADR_W +: DATA_W];

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .expire_o  (tmr_expire)
    );

    always_comb begin
        state_d    = state_q;
        ser_meta_d = ser_i;
        ser_s_d    = ser_meta_q;
        bit_cnt_d  = bit_cnt_q;
        payload_d  = payload_q;
        adr_d      = adr_q;
        data_d     = data_q;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        err_d      = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = FULL_BIT;

        case (state_q)
            ST_IDLE: begin
                if (!ser_s_q) begin
                    tmr_load = 1'b1;
                    tmr_val  = HALF_BIT;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (tmr_expire) begin
                    if (!ser_s_q) begin
                        tmr_load  = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SHIFT: begin
                if (tmr_expire) begin
                    payload_d = {ser_s_q, payload_q[PLD_W-1:1]};
                    tmr_load  = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                // Outputs are registered here so they appear during the ISSUE cycle.
                if (tmr_expire) begin
                    if (ser_s_q) begin
                        rd_d    = (pld_opc == OPC_STORE) || (pld_opc == OPC_DIRECT);
                        wr_d    = (pld_opc == OPC_FETCH) || (pld_opc == OPC_DIRECT);
                        if (pld_opc != OPC_NOP) begin
                            adr_d  = pld_adr;
                            data_d = pld_data;
                        end
                        state_d = ST_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (ser_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            ser_meta_q <= 1'b1;
            ser_s_q    <= 1'b1;
            bit_cnt_q  <= '0;
            payload_q  <= '0;
            adr_q      <= '0;
            data_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ser_meta_q <= ser_meta_d;
            ser_s_q    <= ser_s_d;
            bit_cnt_q  <= bit_cnt_d;
            payload_q  <= payload_d;
            adr_q      <= adr_d;
            data_q     <= data_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
        end
    end

    assign data_o      = data_q;
    assign adr_o       = adr_q;
    assign read_sig_o  = rd_q;
    assign write_sig_o = wr_q;
    assign frame_err_o = err_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_cmd_decoder.sv
// Directed and randomized frames against a frame-level reference model.
module tb_serial_cmd_decoder;

    localparam int CPB = 4;
    localparam int DW  = 8;
    localparam int AW  = 2;
    localparam int NBITS = 2 + AW + DW;
    // ser_i drop -> ser_s visible (3 edges), then half bit + payload + stop bit.
    localparam int LAT   = 3 + CPB / 2 + (NBITS + 1) * CPB;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          ser_i;
    logic [DW-1:0] data_o;
    logic [AW-1:0] adr_o;
    logic          read_sig_o, write_sig_o, busy_o, frame_err_o;

    serial_cmd_decoder #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (DW),
        .ADR_W       (AW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .ser_i      (ser_i),
        .data_o     (data_o),
        .adr_o      (adr_o),
        .read_sig_o (read_sig_o),
        .write_sig_o(write_sig_o),
        .busy_o     (busy_o),
        .frame_err_o(frame_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor plus a stand-in for the downstream data_selector cells.
    int            rd_cnt = 0, wr_cnt = 0, both_cnt = 0, err_cnt = 0;
    int            rd_times[$];
    int            wr_cyc = 0;
    logic [DW-1:0] mem [4] = '{default: '0};
    logic [DW-1:0] fetched = '0;

    always @(negedge clk) begin
        if (read_sig_o) begin
            rd_cnt = rd_cnt + 1;
            rd_times.push_back(cyc);
            mem[adr_o] = data_o;
        end
        if (write_sig_o) begin
            wr_cnt  = wr_cnt + 1;
            wr_cyc  = cyc;
            fetched = mem[adr_o];
        end
        if (read_sig_o && write_sig_o) both_cnt = both_cnt + 1;
        if (frame_err_o) err_cnt = err_cnt + 1;
    end

    int            vectors = 0;
    int            miscompares = 0;
    int            frame_start = 0;
    logic [AW-1:0] exp_adr = '0;
    logic [DW-1:0] exp_data = '0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        vectors = vectors + 1;
        assert (obs === exp_v) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ser_i = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [1:0] opc, input logic [AW-1:0] adr,
                              input logic [DW-1:0] dat, input logic stop);
        logic [NBITS-1:0] pl;
        pl = {dat, adr, opc};
        frame_start = cyc;
        send_bit(1'b0);
        for (int i = 0; i < NBITS; i++) send_bit(pl[i]);
        send_bit(stop);
    endtask

    task automatic chk_outputs_held(input string tag);
        chk({tag, "_adr"},  int'(adr_o),  int'(exp_adr));
        chk({tag, "_data"}, int'(data_o), int'(exp_data));
    endtask

    task automatic do_frame(input logic [1:0] opc, input logic [AW-1:0] adr,
                            input logic [DW-1:0] dat);
        int rb, wb, eb;
        rb = rd_cnt; wb = wr_cnt; eb = err_cnt;
        send_frame(opc, adr, dat, 1'b1);
        ser_i = 1'b1;
        tick(6);
        if (opc != 2'b00) begin
            exp_adr  = adr;
            exp_data = dat;
        end
        chk("rd_pulses", rd_cnt - rb, int'(opc[0]));
        chk("wr_pulses", wr_cnt - wb, int'(opc[1]));
        chk("err_pulses", err_cnt - eb, 0);
        if (opc[0]) chk("rd_time", rd_times[$], frame_start + LAT);
        if (opc[1]) chk("wr_time", wr_cyc, frame_start + LAT);
        chk_outputs_held("frame");
        chk("frame_busy", int'(busy_o), 0);
    endtask

    initial begin
        int rb, wb, eb, bb, s;
        logic [1:0]    r_opc;
        logic [AW-1:0] r_adr;
        logic [DW-1:0] r_dat;

        rst_i = 1'b1;
        ser_i = 1'b1;
        tick(3);
        chk("rst_data", int'(data_o), 0);
        chk("rst_adr", int'(adr_o), 0);
        chk("rst_rd", int'(read_sig_o), 0);
        chk("rst_wr", int'(write_sig_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_err", int'(frame_err_o), 0);
        rst_i = 1'b0;
        tick(3);

        // STORE adr 2 data 0x40, cycle-exact strobe and busy timing.
        rb = rd_cnt; wb = wr_cnt;
        send_frame(2'b01, 2'd2, 8'h40, 1'b1);
        ser_i = 1'b1;
        tick(LAT - (cyc - frame_start));
        chk("store_rd_hi", int'(read_sig_o), 1);
        chk("store_busy_hi", int'(busy_o), 1);
        chk("store_adr", int'(adr_o), 2);
        chk("store_data", int'(data_o), 8'h40);
        tick(1);
        chk("store_rd_lo", int'(read_sig_o), 0);
        chk("store_busy_lo", int'(busy_o), 0);
        tick(4);
        chk("store_rd_cnt", rd_cnt - rb, 1);
        chk("store_wr_cnt", wr_cnt - wb, 0);
        exp_adr = 2'd2; exp_data = 8'h40;

        // Four stores then a fetch through the data_selector stand-in.
        do_frame(2'b01, 2'd0, 8'd64);
        do_frame(2'b01, 2'd1, 8'd32);
        do_frame(2'b01, 2'd2, 8'd2);
        do_frame(2'b01, 2'd3, 8'd1);
        do_frame(2'b10, 2'd1, 8'd0);
        chk("mem0", int'(mem[0]), 64);
        chk("mem1", int'(mem[1]), 32);
        chk("mem2", int'(mem[2]), 2);
        chk("mem3", int'(mem[3]), 1);
        chk("fetch_val", int'(fetched), 32);

        // DIRECT: both strobes in one single cycle.
        bb = both_cnt;
        do_frame(2'b11, 2'd3, 8'h7B);
        chk("direct_both", both_cnt - bb, 1);

        // False start: one-clock low glitch.
        rb = rd_cnt; wb = wr_cnt;
        s = cyc;
        ser_i = 1'b0;
        tick(1);
        ser_i = 1'b1;
        tick(2);
        chk("fs_busy_rise", int'(busy_o), 1);
        tick(2);
        chk("fs_busy_fall", int'(busy_o), 0);
        tick(4);
        chk("fs_rd", rd_cnt - rb, 0);
        chk("fs_wr", wr_cnt - wb, 0);
        chk_outputs_held("fs");
        if (cyc - s > 1000) chk("fs_budget", cyc - s, 0);

        // Bad stop bit, line held low afterwards.
        rb = rd_cnt; wb = wr_cnt; eb = err_cnt;
        send_frame(2'b01, 2'd1, 8'hAA, 1'b0);
        tick(6);
        chk("bs_err", err_cnt - eb, 1);
        chk("bs_rd", rd_cnt - rb, 0);
        chk("bs_wr", wr_cnt - wb, 0);
        chk("bs_busy_low_line", int'(busy_o), 1);
        chk_outputs_held("bs");
        ser_i = 1'b1;
        tick(5);
        chk("bs_busy_released", int'(busy_o), 0);

        // Randomized frames against the frame-level model.
        for (int n = 0; n < 10; n++) begin
            r_opc = 2'($urandom_range(0, 3));
            r_adr = AW'($urandom);
            r_dat = DW'($urandom);
            do_frame(r_opc, r_adr, r_dat);
        end

        // Reset during data bits.
        rb = rd_cnt; wb = wr_cnt;
        ser_i = 1'b0;
        tick(30);
        rst_i = 1'b1;
        tick(1);
        chk("mr_data", int'(data_o), 0);
        chk("mr_adr", int'(adr_o), 0);
        chk("mr_rd", int'(read_sig_o), 0);
        chk("mr_wr", int'(write_sig_o), 0);
        chk("mr_busy", int'(busy_o), 0);
        chk("mr_err", int'(frame_err_o), 0);
        ser_i = 1'b1;
        rst_i = 1'b0;
        exp_adr = '0; exp_data = '0;
        tick(60);
        chk("mr_no_rd", rd_cnt - rb, 0);
        chk("mr_no_wr", wr_cnt - wb, 0);

        // Back-to-back STOREs with no idle gap.
        rb = rd_cnt;
        r_dat = DW'($urandom);
        send_frame(2'b01, 2'd0, 8'h5A, 1'b1);
        send_frame(2'b01, 2'd3, r_dat, 1'b1);
        ser_i = 1'b1;
        tick(6);
        chk("b2b_cnt", rd_cnt - rb, 2);
        if (rd_times.size() >= 2)
            chk("b2b_spacing", rd_times[$] - rd_times[$-1], 14 * CPB);
        else
            chk("b2b_spacing", 0, 14 * CPB);
        chk("b2b_adr", int'(adr_o), 3);
        chk("b2b_data", int'(data_o), int'(r_dat));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
